// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into 32-bit control-decoder words and
// queues them in a small FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [4:0]  SHAMT_FILL = 5'b01010
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Flush,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [3:0]               Op,
  input  logic [4:0]               Rs,
  input  logic [4:0]               Rt,
  input  logic [4:0]               Rd,
  input  logic [15:0]              Imm,
  output logic [31:0]              Instruction,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic                     Err,
  output logic [$clog2(DEPTH):0]   Level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_MUL   = 4'd4,
    OP_NOP   = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7
  } op_e;

  localparam logic [5:0] RTYPE_OPC = 6'b000111;
  localparam logic [5:0] LOAD_OPC  = 6'b001000;
  localparam logic [5:0] STORE_OPC = 6'b001001;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          legal;
  logic [31:0]   word_d;
  logic          full, empty, accept, push, pop;

  always_comb begin
    legal  = 1'b1;
    word_d = '0;
    unique case (Op)
      OP_ADD:   word_d = {RTYPE_OPC, Rs, Rt, Rd, SHAMT_FILL, 6'b100000};
      OP_SUB:   word_d = {RTYPE_OPC, Rs, Rt, Rd, SHAMT_FILL, 6'b100010};
      OP_AND:   word_d = {RTYPE_OPC, Rs, Rt, Rd, SHAMT_FILL, 6'b100100};
      OP_OR:    word_d = {RTYPE_OPC, Rs, Rt, Rd, SHAMT_FILL, 6'b100101};
      OP_MUL:   word_d = {RTYPE_OPC, Rs, Rt, Rd, SHAMT_FILL, 6'b110010};
      OP_NOP:   word_d = {RTYPE_OPC, 15'd0, SHAMT_FILL, 6'b111111};
      OP_LOAD:  word_d = {LOAD_OPC, Rs, Rt, Imm};
      OP_STORE: word_d = {STORE_OPC, Rs, Rt, Imm};
      default:  legal  = 1'b0;
    endcase
  end

  assign full      = (count_q == LW'(DEPTH));
  assign empty     = (count_q == '0);
  assign In_Ready  = !full;
  assign Out_Valid = !empty;
  assign Level     = count_q;
  assign Err       = err_q;
  assign Instruction = Out_Valid ? mem_q[rd_ptr_q] : 32'h0;

  // Flush overrides both sides; an illegal request still consumes the handshake.
  assign accept = In_Valid && In_Ready && !Flush;
  assign push   = accept && legal;
  assign pop    = Out_Valid && Out_Ready && !Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = accept && !legal;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= word_d;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer-side counterpart of the control decoder. It accepts symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake.
- Each legal request is packed into the 32-bit instruction word format that the control decoder consumes. Packed words are buffered in a small FIFO and presented on Instruction with an output valid/ready handshake.
- It is used as a programmable instruction source feeding control, and as a stimulus generator for CPU-level benches.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- SHAMT_FILL, 5'b01010, constant placed in bits [10:6] of every R-type word.

Ports:
- Clk  input  1  single clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Flush  input  1  synchronous FIFO clear.
- In_Valid  input  1  request valid.
- In_Ready  output  1  request accepted when In_Valid && In_Ready.
- Op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 NOP, 6 LOAD, 7 STORE; 8-15 are illegal.
- Rs  input  5  source register.
- Rt  input  5  second source / load-store register.
- Rd  input  5  destination register (R-type only).
- Imm  input  16  immediate (LOAD/STORE only).
- Instruction  output  32  encoded word at FIFO head.
- Out_Valid  output  1  Instruction valid.
- Out_Ready  input  1  consumer takes the word when Out_Valid && Out_Ready.
- Err  output  1  one-cycle pulse on an illegal Op acceptance.
- Level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (Reset_n=0, asynchronous): FIFO empty, Level=0, Out_Valid=0, Instruction=32'h0, Err=0. In_Ready=1 when reset is released. Reset asserted mid-operation discards all buffered words immediately.
- Encoding, R-type (ADD/SUB/AND/OR/MUL): [31:26]=6'b000111, [25:21]=Rs, [20:16]=Rt, [15:11]=Rd, [10:6]=SHAMT_FILL, [5:0]=funct.
  - funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, MUL 110010.
- NOP: 6'b000111, Rs/Rt/Rd forced to 0, SHAMT_FILL, funct 111111. Input register fields are ignored.
- LOAD: [31:26]=001000, Rs, Rt, [15:0]=Imm.
- STORE: [31:26]=001001, Rs, Rt, [15:0]=Imm.
- Rd is ignored for LOAD/STORE; Imm is ignored for R-type.
- In_Ready = !full. In_Ready is combinational from occupancy only and does not depend on In_Valid or Out_Ready.
- Push: an accepted legal request is written to the tail at the rising edge.
  - Latency: accepted in cycle N, visible at the head in cycle N+1 if the FIFO was empty.
- Illegal Op (8-15): still accepted (consumes the handshake) but not written. Err=1 for exactly cycle N+1. Level is unchanged.
- Pop: Out_Valid = !empty. Instruction = head word while Out_Valid, else 32'h0. On Out_Valid && Out_Ready the head advances at the edge.
- Simultaneous push and pop when not full and not empty: Level is unchanged and ordering is preserved.
- Full: In_Ready=0 even if Out_Ready=1 in the same cycle; no bypass.
- Empty with Out_Ready=1: no pop, no underflow, pointers hold.
- Pointers wrap modulo DEPTH. Level reaches DEPTH exactly at full.
- Flush=1: FIFO cleared at the edge; Out_Valid=0 the next cycle.
  - Flush has priority over a push or pop in the same cycle; that push is dropped and no Err is raised.
- Words leave the FIFO in strict acceptance order.
- Instruction is stable while Out_Valid && !Out_Ready.

Test Plan:
- ADD Rs=3 Rt=4 Rd=9, Out_Ready=1 -> next cycle Out_Valid=1, Instruction=32'h1C644AA0; Level returns to 0 after the pop.
- MUL 1/2/8, NOP (Rs=7), LOAD Rs=0 Rt=1 Imm=16'h4000, STORE Rs=10 Rt=10 Imm=16'h43FF, with Out_Ready=1 -> words 32'h1C2242B2, 32'h1C0002BF, 32'h20014000, 32'h254A43FF in order.
- Out_Ready=0, push 5 legal requests with DEPTH=4 -> In_Ready falls after the 4th acceptance, Level=4, 5th request held off. Raise Out_Ready -> 4 words drain in order, In_Ready=1 after the first pop.
- Op=4'hB with In_Valid=1 -> In_Ready=1, Err pulses high for exactly one cycle, Level unchanged, no Out_Valid.
- With 3 entries, assert Flush together with In_Valid -> Level=0, Out_Valid=0 next cycle, pushed word absent.
- Drop Reset_n asynchronously mid-stream with 2 entries -> Out_Valid, Instruction, Level go to 0 immediately without a clock edge. After release, a fresh ADD appears first.
